// File: rtl/led_cmd_pkg.sv
// Shared constants, FSM state type and hex helpers for the led_cmd_pwm command interpreter.
package led_cmd_pkg;

  localparam logic [7:0] CMD_TOGGLE = 8'h74;  // 't'
  localparam logic [7:0] CMD_PWM    = 8'h70;  // 'p'
  localparam logic [7:0] CMD_QUERY  = 8'h3F;  // '?'
  localparam logic [7:0] CMD_ALLOFF = 8'h7A;  // 'z'
  localparam logic [7:0] RSP_OK     = 8'h6B;  // 'k'
  localparam logic [7:0] RSP_ERR    = 8'h78;  // 'x'
  localparam logic [7:0] RSP_ONE    = 8'h31;  // '1'
  localparam logic [7:0] RSP_ZERO   = 8'h30;  // '0'
  localparam logic [7:0] CR         = 8'h0D;
  localparam logic [7:0] LF         = 8'h0A;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_GET_CH = 3'd1,
    ST_GET_HI = 3'd2,
    ST_GET_LO = 3'd3,
    ST_EXEC   = 3'd4,
    ST_REPLY  = 3'd5
  } state_e;

  typedef struct packed {
    logic       valid;
    logic [3:0] nib;
  } hex_nib_t;

  function automatic hex_nib_t hex_to_nib(input logic [7:0] c);
    hex_nib_t r;
    r.valid = 1'b1;
    r.nib   = 4'h0;
    if (c >= 8'h30 && c <= 8'h39) begin
      r.nib = 4'(c - 8'h30);
    end else if (c >= 8'h61 && c <= 8'h66) begin
      r.nib = 4'(c - 8'h57);
    end else if (c >= 8'h41 && c <= 8'h46) begin
      r.nib = 4'(c - 8'h37);
    end else begin
      r.valid = 1'b0;
    end
    return r;
  endfunction

  function automatic logic [7:0] nib_to_hex(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

endpackage

// File: rtl/led_cmd_pwm_if.sv
// Byte-stream ready/valid pipes between the host UART path and led_cmd_pwm.
interface led_cmd_pwm_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );
endinterface

// File: rtl/led_cmd_pwm_gen.sv
// Shared prescaler, 8-bit PWM step counter and registered per-channel duty comparators.
module led_cmd_pwm_gen #(
  parameter int unsigned CHANNELS = 3,
  parameter int unsigned PWM_DIV  = 188
) (
  input  logic                    clk_48mhz,
  input  logic                    reset_n,
  input  logic [CHANNELS-1:0]     en,
  input  logic [8*CHANNELS-1:0]   duty_flat,
  output logic [CHANNELS-1:0]     led_pwm
);

  localparam int unsigned PW = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PWM_DIV - 1);

  logic [PW-1:0]       presc_q, presc_d;
  logic [7:0]          pwm_cnt_q, pwm_cnt_d;
  logic [CHANNELS-1:0] led_pwm_q, led_pwm_d;
  logic                presc_wrap_s;

  // next prescaler/step counter and comparator outputs
  always_comb begin
    presc_wrap_s = (presc_q == PRESC_LAST);
    presc_d      = presc_wrap_s ? {PW{1'b0}} : (presc_q + PW'(1));
    pwm_cnt_d    = presc_wrap_s ? (pwm_cnt_q + 8'd1) : pwm_cnt_q;
    led_pwm_d    = {CHANNELS{1'b0}};
    for (int i = 0; i < CHANNELS; i++) begin
      led_pwm_d[i] = en[i] && (pwm_cnt_q < duty_flat[i*8 +: 8]);
    end
  end

  // PWM state registers
  always_ff @(posedge clk_48mhz) begin
    if (!reset_n) begin
      presc_q   <= {PW{1'b0}};
      pwm_cnt_q <= 8'd0;
      led_pwm_q <= {CHANNELS{1'b0}};
    end else begin
      presc_q   <= presc_d;
      pwm_cnt_q <= pwm_cnt_d;
      led_pwm_q <= led_pwm_d;
    end
  end

  assign led_pwm = led_pwm_q;

endmodule

// File: rtl/led_cmd_pwm.sv
// ASCII command interpreter driving CHANNELS PWM LEDs with duty/enable control and query replies.
// Optional LED_CMD_TIMEOUT_EN aborts a stalled partial command after TIMEOUT_CYCLES idle cycles.
module led_cmd_pwm
  import led_cmd_pkg::*;
#(
  parameter int unsigned CHANNELS       = 3,
  parameter int unsigned PWM_DIV        = 188,
  parameter logic [7:0]  RESET_DUTY     = 8'hFF,
  parameter int unsigned TIMEOUT_CYCLES = 48000000
) (
  input  logic                clk_48mhz,
  input  logic                reset_n,
  led_cmd_pwm_if.slave        bus,
  output logic [CHANNELS-1:0] led_pwm,
  output logic [CHANNELS-1:0] led_en
);

  state_e              state_q, state_d;
  logic [7:0]          cmd_q, cmd_d;
  logic [3:0]          ch_q, ch_d;
  logic [3:0]          hi_q, hi_d;
  logic [3:0]          lo_q, lo_d;
  logic                err_q, err_d;
  logic [CHANNELS-1:0] en_q, en_d;
  logic [7:0]          duty_q [CHANNELS];
  logic [7:0]          duty_d [CHANNELS];
  logic [7:0]          out_data_q, out_data_d;
  logic                out_valid_q, out_valid_d;
  logic                in_ready_q, in_ready_d;
  logic [7:0]          rsp1_q, rsp1_d;
  logic [7:0]          rsp2_q, rsp2_d;
  logic [1:0]          rsp_left_q, rsp_left_d;

  logic                in_acc_s, out_acc_s, timeout_s, ch_ok_s, sel_en_s;
  logic [7:0]          digit_s, sel_duty_s;
  logic [8*CHANNELS-1:0] duty_flat_s;
  hex_nib_t            nib_s;

  assign in_acc_s  = bus.in_valid & in_ready_q;
  assign out_acc_s = out_valid_q & bus.out_ready;
  assign nib_s     = hex_to_nib(bus.in_data);
  assign digit_s   = bus.in_data - 8'h30;
  assign ch_ok_s   = (bus.in_data >= 8'h30) && (bus.in_data <= 8'h39) && (digit_s < 8'(CHANNELS));

  // addressed-channel readback and flattened duty bus for the PWM generator
  always_comb begin
    sel_duty_s  = 8'h00;
    sel_en_s    = 1'b0;
    duty_flat_s = {(8*CHANNELS){1'b0}};
    for (int i = 0; i < CHANNELS; i++) begin
      sel_duty_s           = (ch_q == 4'(i)) ? duty_q[i] : sel_duty_s;
      sel_en_s             = (ch_q == 4'(i)) ? en_q[i]   : sel_en_s;
      duty_flat_s[i*8 +: 8] = duty_q[i];
    end
  end

  // command FSM next-state, register updates and reply sequencing
  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    ch_d        = ch_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    err_d       = err_q;
    en_d        = en_q;
    duty_d      = duty_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    rsp1_d      = rsp1_q;
    rsp2_d      = rsp2_q;
    rsp_left_d  = rsp_left_q;
    case (state_q)
      ST_IDLE: begin
        if (in_acc_s) begin
          case (bus.in_data)
            CMD_TOGGLE, CMD_PWM, CMD_QUERY: begin
              cmd_d   = bus.in_data;
              err_d   = 1'b0;
              state_d = ST_GET_CH;
            end
            CMD_ALLOFF: begin
              cmd_d   = bus.in_data;
              err_d   = 1'b0;
              state_d = ST_EXEC;
            end
            CR, LF: begin
              state_d = ST_IDLE;
            end
            default: begin
              cmd_d   = bus.in_data;
              err_d   = 1'b1;
              state_d = ST_EXEC;
            end
          endcase
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GET_CH: begin
        if (in_acc_s) begin
          if (ch_ok_s) begin
            ch_d    = digit_s[3:0];
            state_d = (cmd_q == CMD_PWM) ? ST_GET_HI : ST_EXEC;
          end else begin
            err_d   = 1'b1;
            state_d = ST_EXEC;
          end
        end else if (timeout_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_GET_CH;
        end
      end
      ST_GET_HI: begin
        if (in_acc_s) begin
          hi_d    = nib_s.nib;
          err_d   = ~nib_s.valid;
          state_d = nib_s.valid ? ST_GET_LO : ST_EXEC;
        end else if (timeout_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_GET_HI;
        end
      end
      ST_GET_LO: begin
        if (in_acc_s) begin
          lo_d    = nib_s.nib;
          err_d   = ~nib_s.valid;
          state_d = ST_EXEC;
        end else if (timeout_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_GET_LO;
        end
      end
      ST_EXEC: begin
        out_valid_d = 1'b1;
        out_data_d  = RSP_OK;
        rsp_left_d  = 2'd0;
        state_d     = ST_REPLY;
        if (err_q) begin
          out_data_d = RSP_ERR;
        end else begin
          case (cmd_q)
            CMD_TOGGLE: begin
              for (int i = 0; i < CHANNELS; i++) begin
                en_d[i] = (ch_q == 4'(i)) ? ~en_q[i] : en_q[i];
              end
            end
            CMD_PWM: begin
              for (int i = 0; i < CHANNELS; i++) begin
                duty_d[i] = (ch_q == 4'(i)) ? {hi_q, lo_q} : duty_q[i];
              end
            end
            CMD_QUERY: begin
              out_data_d = nib_to_hex(sel_duty_s[7:4]);
              rsp1_d     = nib_to_hex(sel_duty_s[3:0]);
              rsp2_d     = sel_en_s ? RSP_ONE : RSP_ZERO;
              rsp_left_d = 2'd2;
            end
            CMD_ALLOFF: begin
              en_d = {CHANNELS{1'b0}};
            end
            default: begin
              out_data_d = RSP_ERR;
            end
          endcase
        end
      end
      ST_REPLY: begin
        if (out_acc_s) begin
          if (rsp_left_q == 2'd0) begin
            out_valid_d = 1'b0;
            state_d     = ST_IDLE;
          end else begin
            out_data_d = rsp1_q;
            rsp1_d     = rsp2_q;
            rsp_left_d = rsp_left_q - 2'd1;
          end
        end else begin
          state_d = ST_REPLY;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
    in_ready_d = (state_d == ST_IDLE) || (state_d == ST_GET_CH) ||
                 (state_d == ST_GET_HI) || (state_d == ST_GET_LO);
  end

  // interpreter state registers
  always_ff @(posedge clk_48mhz) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      cmd_q       <= 8'h00;
      ch_q        <= 4'h0;
      hi_q        <= 4'h0;
      lo_q        <= 4'h0;
      err_q       <= 1'b0;
      en_q        <= {CHANNELS{1'b1}};
      for (int i = 0; i < CHANNELS; i++) begin
        duty_q[i] <= RESET_DUTY;
      end
      out_data_q  <= 8'h00;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
      rsp1_q      <= 8'h00;
      rsp2_q      <= 8'h00;
      rsp_left_q  <= 2'd0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      ch_q        <= ch_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      err_q       <= err_d;
      en_q        <= en_d;
      duty_q      <= duty_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      rsp1_q      <= rsp1_d;
      rsp2_q      <= rsp2_d;
      rsp_left_q  <= rsp_left_d;
    end
  end

`ifdef LED_CMD_TIMEOUT_EN
  logic [31:0] to_cnt_q, to_cnt_d;
  logic        in_get_s;

  assign in_get_s  = (state_q == ST_GET_CH) || (state_q == ST_GET_HI) || (state_q == ST_GET_LO);
  assign timeout_s = in_get_s && (to_cnt_q == 32'(TIMEOUT_CYCLES - 1));

  // idle counter for partial commands, cleared by any accepted byte
  always_comb begin
    to_cnt_d = 32'd0;
    if (in_acc_s) begin
      to_cnt_d = 32'd0;
    end else if (in_get_s) begin
      to_cnt_d = to_cnt_q + 32'd1;
    end else begin
      to_cnt_d = 32'd0;
    end
  end

  // timeout counter register
  always_ff @(posedge clk_48mhz) begin
    if (!reset_n) begin
      to_cnt_q <= 32'd0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end
`else
  assign timeout_s = (TIMEOUT_CYCLES == 32'd0) && 1'b0;
`endif

  led_cmd_pwm_gen #(
    .CHANNELS (CHANNELS),
    .PWM_DIV  (PWM_DIV)
  ) u_gen (
    .clk_48mhz (clk_48mhz),
    .reset_n   (reset_n),
    .en        (en_q),
    .duty_flat (duty_flat_s),
    .led_pwm   (led_pwm)
  );

  assign bus.in_ready  = in_ready_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign led_en        = en_q;

endmodule
